sevenseg_capture: RTL and testbench
===================================

Name: sevenseg_capture

Overview:
- Receive-side counterpart of the multiplexed 7-segment driver: samples the time-multiplexed seg/dig lines of a scanned display.
- Filters each digit dwell, decodes the segment pattern back to a 4-bit hex value and assembles complete frames of N digits.
- Used for board-to-board display readback and as a self-check monitor for the display path.

Parameters:
- N, 2, number of multiplexed digits (N >= 2).
- STABLE_CYCLES, 3, consecutive identical synchronized samples required before a dwell is accepted (>= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- seg_in  in  7  segment lines, active-low, seg_in[0]=a … seg_in[6]=g
- dig_in  in  N  digit selects, active-low one-hot
- err_clr  in  1  clears sticky error flags
- frame_value  out  4 x N (unpacked [N])  decoded hex value per digit, index = dig bit position
- frame_blank  out  N  1 = digit was blank (seg all-ones)
- frame_valid  out  1  single-cycle pulse: frame_value/frame_blank updated
- err_multi  out  1  sticky: more than one dig line low, held for a full dwell
- err_code  out  1  sticky: accepted pattern not in decode table

Behaviour:
- Reset (reset=0 at a clk edge): all outputs are 0, frame_value all 0; sync flops = all-ones; counter = 0; state = SETTLE; seen-mask = 0.
- Input sync: seg_in and dig_in each pass through 2 flops. S = {seg, dig} at the second flop.
- Stability counter: if S differs from its value on the previous cycle, the counter loads 1. Otherwise it increments, saturating at STABLE_CYCLES.
- FSM states:
  - SETTLE: when the counter reaches STABLE_CYCLES, evaluate the dwell (next bullet) and go to LOCKED.
  - LOCKED: ignore S until it changes, then go to SETTLE.
  - A given dwell is evaluated exactly once, however long it lasts.
- Dwell evaluation:
  - dig all-ones: idle, no action.
  - Exactly one dig bit low at index i: decode seg, store it in working slot i, set seen[i].
  - Two or more dig bits low: set err_multi; no store.
  - seg = 7'h7F: blank[i]=1, value[i]=0.
  - Valid seg code: blank[i]=0, value[i]=decoded value.
  - Any other seg code: set err_code; slot i is left unchanged and seen[i] is not set.
- Decode table (active-low, hex value -> seg): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->78, 8->00, 9->10, A->08, b->03, C->46, d->21, E->06, F->0E.
- Frame completion:
  - A frame completes on the evaluation edge where seen becomes all-ones.
  - On that edge the working slots, including the slot written on that edge, are copied to frame_value/frame_blank, frame_valid is 1 for exactly that cycle, and seen clears.
  - Scan order is irrelevant. Repeated digits before completion overwrite the working slot.
- Latency: with pins stable from edge E0 onward (E0 is the first edge that samples the new value), the working slot updates on edge E(STABLE_CYCLES+1), and frame_valid is asserted after that edge when it completes the frame.
- Errors:
  - err_multi and err_code stay 1 until err_clr=1 or reset.
  - If err_clr and a new error occur on the same edge, the error wins (flag stays 1).
- Reset mid-frame discards the working slots and the seen-mask. frame outputs return to 0.
- Glitches shorter than STABLE_CYCLES samples are never evaluated.

Optional Feature:
- Macro: SEVENSEG_CAPTURE_RAW_EN.
- When defined: adds output frame_raw [N] x 7, the raw accepted seg pattern per digit. It is snapshotted together with frame_value. Patterns rejected with err_code are still stored in the working raw slot, but do not set seen.
- When undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with random pins -> all outputs 0; no frame_valid for STABLE_CYCLES+1 edges after release with dig_in=2'b11.
- Nominal N=2, STABLE_CYCLES=3: alternate dig=10/seg=30 and dig=01/seg=19, 8 cycles per dwell -> frame_valid pulses once per full scan; frame_value[0]=3, frame_value[1]=4; first working-slot update exactly 4 edges after the pin change.
- Glitch: insert a 2-cycle dig=01/seg=00 dwell inside a digit-0 scan -> no update, no frame_valid, no error.
- Blank and all codes: sweep all 16 codes plus 7F on digit 1 -> each decodes correctly; 7F gives frame_blank[1]=1 and frame_value[1]=0.
- Errors: dig=00 held 5 cycles -> err_multi=1, no store. seg=7'h55 held -> err_code=1. err_clr pulse -> both 0. err_clr on the same edge as a new error -> flag remains 1.
- Reset mid-frame: capture digit 0 only, pulse reset, then capture digit 1 only -> no frame_valid until digit 0 is seen again.

Source files
------------

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: samples a scanned 7-segment display and rebuilds N-digit hex frames.
// Define SEVENSEG_CAPTURE_RAW_EN to add frame_raw, the raw accepted segment pattern per digit.
module sevenseg_capture #(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [6:0]   seg_in,
  input  logic [N-1:0] dig_in,
  input  logic         err_clr,
  output logic [3:0]   frame_value [N],
  output logic [N-1:0] frame_blank,
  output logic         frame_valid,
  output logic         err_multi,
  output logic         err_code
`ifdef SEVENSEG_CAPTURE_RAW_EN
  ,
  output logic [6:0]   frame_raw [N]
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = 7 + N;

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t         state, state_next;
  logic [6:0]     seg_s1, seg_s2;
  logic [N-1:0]   dig_s1, dig_s2;
  logic [SW-1:0]  s_cur, s_prev;
  logic           s_changed;
  logic [CW-1:0]  cnt, cnt_next;
  logic           eval;

  logic [N-1:0]   dig_low;
  logic           one_low, multi_low;
  logic           is_blank, code_ok;
  logic [3:0]     code_val;
  logic           store, set_multi, set_code, complete;

  logic [N-1:0]   seen, seen_next;
  logic [3:0]     work_val [N];
  logic [3:0]     work_val_next [N];
  logic [N-1:0]   work_blank, work_blank_next;

  assign s_cur     = {seg_s2, dig_s2};
  assign s_changed = (s_cur != s_prev);

  always_comb begin
    cnt_next = cnt;
    if (s_changed)
      cnt_next = CW'(1);
    else if (cnt != CW'(STABLE_CYCLES))
      cnt_next = cnt + CW'(1);
  end

  // A dwell is evaluated on the edge its run reaches STABLE_CYCLES; LOCKED blocks re-evaluation.
  always_comb begin
    state_next = state;
    eval       = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt_next == CW'(STABLE_CYCLES)) begin
          eval       = 1'b1;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (s_changed)
          state_next = SETTLE;
      end
      default: state_next = SETTLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= SETTLE;
    else
      state <= state_next;
  end

  assign dig_low   = ~dig_s2;
  assign multi_low = |(dig_low & (dig_low - N'(1)));
  assign one_low   = (|dig_low) && !multi_low;
  assign is_blank  = (seg_s2 == 7'h7F);

  always_comb begin
    code_ok  = 1'b1;
    code_val = 4'h0;
    case (seg_s2)
      7'h40: code_val = 4'h0;
      7'h79: code_val = 4'h1;
      7'h24: code_val = 4'h2;
      7'h30: code_val = 4'h3;
      7'h19: code_val = 4'h4;
      7'h12: code_val = 4'h5;
      7'h02: code_val = 4'h6;
      7'h78: code_val = 4'h7;
      7'h00: code_val = 4'h8;
      7'h10: code_val = 4'h9;
      7'h08: code_val = 4'hA;
      7'h03: code_val = 4'hB;
      7'h46: code_val = 4'hC;
      7'h21: code_val = 4'hD;
      7'h06: code_val = 4'hE;
      7'h0E: code_val = 4'hF;
      default: code_ok = 1'b0;
    endcase
  end

  assign store     = eval && one_low && (is_blank || code_ok);
  assign set_code  = eval && one_low && !is_blank && !code_ok;
  assign set_multi = eval && multi_low;
  assign seen_next = seen | (store ? dig_low : '0);
  assign complete  = store && (&seen_next);

  // Next working slots include this edge's store so a completing frame copies it too.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      work_val_next[i] = work_val[i];
      if (store && dig_low[i])
        work_val_next[i] = is_blank ? 4'h0 : code_val;
    end
    work_blank_next = work_blank;
    if (store)
      work_blank_next = is_blank ? (work_blank | dig_low) : (work_blank & ~dig_low);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_s1      <= '1;
      seg_s2      <= '1;
      dig_s1      <= '1;
      dig_s2      <= '1;
      s_prev      <= '1;
      cnt         <= '0;
      seen        <= '0;
      work_blank  <= '0;
      frame_blank <= '0;
      frame_valid <= 1'b0;
      err_multi   <= 1'b0;
      err_code    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        work_val[i]    <= 4'h0;
        frame_value[i] <= 4'h0;
      end
    end else begin
      seg_s1      <= seg_in;
      seg_s2      <= seg_s1;
      dig_s1      <= dig_in;
      dig_s2      <= dig_s1;
      s_prev      <= s_cur;
      cnt         <= cnt_next;
      seen        <= complete ? '0 : seen_next;
      work_blank  <= work_blank_next;
      frame_valid <= complete;
      err_multi   <= set_multi | (err_multi & ~err_clr);
      err_code    <= set_code | (err_code & ~err_clr);
      for (int i = 0; i < N; i++)
        work_val[i] <= work_val_next[i];
      if (complete) begin
        frame_blank <= work_blank_next;
        for (int i = 0; i < N; i++)
          frame_value[i] <= work_val_next[i];
      end
    end
  end

`ifdef SEVENSEG_CAPTURE_RAW_EN
  logic [6:0] work_raw [N];
  logic [6:0] work_raw_next [N];

  // Raw slots also capture rejected patterns, which never mark the digit as seen.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      work_raw_next[i] = work_raw[i];
      if (eval && one_low && dig_low[i])
        work_raw_next[i] = seg_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        work_raw[i]  <= 7'h00;
        frame_raw[i] <= 7'h00;
      end
    end else begin
      for (int i = 0; i < N; i++)
        work_raw[i] <= work_raw_next[i];
      if (complete)
        for (int i = 0; i < N; i++)
          frame_raw[i] <= work_raw_next[i];
    end
  end
`endif

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb_sevenseg_capture: directed and random scans of sevenseg_capture against a dwell-level model.
module tb_sevenseg_capture;

  localparam int N      = 2;
  localparam int STABLE = 3;
  localparam int SW     = 7 + N;

  logic         clk = 1'b0;
  logic         reset;
  logic [6:0]   seg_in;
  logic [N-1:0] dig_in;
  logic         err_clr;
  logic [3:0]   frame_value [N];
  logic [N-1:0] frame_blank;
  logic         frame_valid;
  logic         err_multi;
  logic         err_code;
`ifdef SEVENSEG_CAPTURE_RAW_EN
  logic [6:0]   frame_raw [N];
`endif

  sevenseg_capture #(.N(N), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .dig_in      (dig_in),
    .err_clr     (err_clr),
    .frame_value (frame_value),
    .frame_blank (frame_blank),
    .frame_valid (frame_valid),
    .err_multi   (err_multi),
    .err_code    (err_code)
`ifdef SEVENSEG_CAPTURE_RAW_EN
    ,
    .frame_raw   (frame_raw)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_table [16];

  // Model: pins reach the evaluator two edges late; a run of STABLE identical samples is judged once.
  logic [SW-1:0] mp1, mp2, mprev;
  int            mrun;
  bit            mdone;
  logic [N-1:0]  mseen, mblank, eb;
  logic [3:0]    mval [N];
  logic [3:0]    ev [N];
  logic [6:0]    mraw [N];
  logic [6:0]    eraw [N];
  logic          evalid, emulti, ecode;

  task automatic modelEdge();
    logic [SW-1:0] s_now;
    logic [6:0]    sg;
    logic [N-1:0]  dg;
    int            lows, idx;
    bit            found, set_m, set_c;
    logic [3:0]    v;
    evalid = 1'b0;
    set_m  = 0;
    set_c  = 0;
    if (reset !== 1'b1) begin
      mp1 = '1; mp2 = '1; mprev = '1;
      mrun = 0; mdone = 0;
      mseen = '0; mblank = '0; eb = '0;
      emulti = 1'b0; ecode = 1'b0;
      for (int i = 0; i < N; i++) begin
        mval[i] = 4'h0; ev[i] = 4'h0; mraw[i] = 7'h00; eraw[i] = 7'h00;
      end
    end else begin
      s_now = mp2;
      mp2   = mp1;
      mp1   = {seg_in, dig_in};
      if (s_now !== mprev) begin
        mrun  = 1;
        mdone = 0;
      end else if (mrun < STABLE) begin
        mrun++;
      end
      mprev = s_now;
      if (!mdone && mrun == STABLE) begin
        mdone = 1;
        sg    = s_now[SW-1:N];
        dg    = s_now[N-1:0];
        lows  = 0;
        idx   = 0;
        for (int i = 0; i < N; i++)
          if (!dg[i]) begin lows++; idx = i; end
        if (lows >= 2) begin
          set_m = 1;
        end else if (lows == 1) begin
          mraw[idx] = sg;
          found = 0;
          v = 4'h0;
          for (int c = 0; c < 16; c++)
            if (seg_table[c] == sg) begin found = 1; v = 4'(c); end
          if (sg == 7'h7F) begin
            mblank[idx] = 1'b1; mval[idx] = 4'h0; mseen[idx] = 1'b1;
          end else if (found) begin
            mblank[idx] = 1'b0; mval[idx] = v; mseen[idx] = 1'b1;
          end else begin
            set_c = 1;
          end
          if (&mseen) begin
            for (int i = 0; i < N; i++) begin ev[i] = mval[i]; eraw[i] = mraw[i]; end
            eb     = mblank;
            evalid = 1'b1;
            mseen  = '0;
          end
        end
      end
      emulti = set_m ? 1'b1 : (err_clr ? 1'b0 : emulti);
      ecode  = set_c ? 1'b1 : (err_clr ? 1'b0 : ecode);
    end
  endtask

  task automatic checkOutput();
    checks++;
    assert (frame_valid === evalid) else begin
      errors++;
      $error("[TB] FAIL frame_valid observed=%0b expected=%0b t=%0t", frame_valid, evalid, $time);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      assert (frame_value[i] === ev[i]) else begin
        errors++;
        $error("[TB] FAIL frame_value[%0d] observed=%0h expected=%0h t=%0t", i, frame_value[i], ev[i], $time);
      end
`ifdef SEVENSEG_CAPTURE_RAW_EN
      checks++;
      assert (frame_raw[i] === eraw[i]) else begin
        errors++;
        $error("[TB] FAIL frame_raw[%0d] observed=%0h expected=%0h t=%0t", i, frame_raw[i], eraw[i], $time);
      end
`endif
    end
    checks++;
    assert (frame_blank === eb) else begin
      errors++;
      $error("[TB] FAIL frame_blank observed=%0b expected=%0b t=%0t", frame_blank, eb, $time);
    end
    checks++;
    assert (err_multi === emulti) else begin
      errors++;
      $error("[TB] FAIL err_multi observed=%0b expected=%0b t=%0t", err_multi, emulti, $time);
    end
    checks++;
    assert (err_code === ecode) else begin
      errors++;
      $error("[TB] FAIL err_code observed=%0b expected=%0b t=%0t", err_code, ecode, $time);
    end
  endtask

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(output bit v);
    modelEdge();
    @(posedge clk);
    #1;
    v = frame_valid;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [6:0] sg, input logic [N-1:0] dg, input int cycles,
                               output int nvalid);
    bit v;
    seg_in = sg;
    dig_in = dg;
    nvalid = 0;
    for (int k = 0; k < cycles; k++) begin
      tick(v);
      if (v) nvalid++;
    end
  endtask

  initial begin
    int nv, total, hit;
    bit v;
    logic [6:0] sg;
    logic [N-1:0] dg;
    seg_table = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    reset   = 1'b0;
    err_clr = 1'b0;
    seg_in  = 7'($urandom);
    dig_in  = N'($urandom);

    // Reset with random pins, then idle release
    for (int k = 0; k < 3; k++) begin
      seg_in = 7'($urandom);
      dig_in = N'($urandom);
      tick(v);
    end
    checkEq("reset_valid", {31'd0, frame_valid}, 32'd0);
    checkEq("reset_value0", {28'd0, frame_value[0]}, 32'd0);
    checkEq("reset_errs", {30'd0, err_multi, err_code}, 32'd0);
    reset = 1'b1;
    applyStimulus(7'h7F, 2'b11, STABLE + 1, nv);
    checkEq("idle_no_valid", nv, 0);

    // Nominal scan with latency measurement on the completing digit
    applyStimulus(7'h30, 2'b10, 8, nv);
    seg_in = 7'h19;
    dig_in = 2'b01;
    hit = -1;
    for (int k = 0; k < 8; k++) begin
      tick(v);
      if (v && hit < 0) hit = k;
    end
    checkEq("latency_edges", hit, STABLE + 1);
    total = 0;
    for (int s = 0; s < 3; s++) begin
      applyStimulus(7'h30, 2'b10, 8, nv); total += nv;
      applyStimulus(7'h19, 2'b01, 8, nv); total += nv;
    end
    checkEq("scan_pulses", total, 3);
    checkEq("nominal_value0", {28'd0, frame_value[0]}, 32'd3);
    checkEq("nominal_value1", {28'd0, frame_value[1]}, 32'd4);

    // Short glitch on digit 1 during a digit-0 dwell
    total = 0;
    applyStimulus(7'h40, 2'b10, 8, nv); total += nv;
    applyStimulus(7'h00, 2'b01, 2, nv); total += nv;
    applyStimulus(7'h40, 2'b10, 8, nv); total += nv;
    checkEq("glitch_no_valid", total, 0);
    checkEq("glitch_no_err", {30'd0, err_multi, err_code}, 32'd0);

    // Every code plus blank on digit 1
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(7'h40, 2'b10, 6, nv);
      applyStimulus((c == 16) ? 7'h7F : seg_table[c], 2'b01, 6, nv);
      checkEq("sweep_pulse", nv, 1);
      checkEq("sweep_value1", {28'd0, frame_value[1]}, (c == 16) ? 32'd0 : 32'(c));
      checkEq("sweep_blank1", {31'd0, frame_blank[1]}, (c == 16) ? 32'd1 : 32'd0);
    end

    // Error flags: set, clear, and clear colliding with a new error
    applyStimulus(7'h7F, 2'b00, 5, nv);
    checkEq("err_multi_set", {31'd0, err_multi}, 32'd1);
    applyStimulus(7'h55, 2'b10, 6, nv);
    checkEq("err_code_set", {31'd0, err_code}, 32'd1);
    applyStimulus(7'h7F, 2'b11, 6, nv);
    err_clr = 1'b1;
    applyStimulus(7'h7F, 2'b11, 1, nv);
    err_clr = 1'b0;
    checkEq("err_cleared", {30'd0, err_multi, err_code}, 32'd0);
    applyStimulus(7'h7F, 2'b00, 4, nv);
    err_clr = 1'b1;
    applyStimulus(7'h7F, 2'b00, 1, nv);
    err_clr = 1'b0;
    checkEq("err_clr_collide", {31'd0, err_multi}, 32'd1);
    applyStimulus(7'h7F, 2'b00, 3, nv);
    err_clr = 1'b1;
    applyStimulus(7'h7F, 2'b11, 1, nv);
    err_clr = 1'b0;

    // Reset in the middle of a frame
    applyStimulus(7'h40, 2'b10, 8, nv);
    reset = 1'b0;
    applyStimulus(7'h40, 2'b10, 2, nv);
    reset = 1'b1;
    applyStimulus(7'h79, 2'b01, 8, nv);
    checkEq("midreset_no_valid", nv, 0);
    applyStimulus(7'h40, 2'b10, 8, nv);
    checkEq("midreset_complete", nv, 1);

    // Random scans with occasional error clears
    for (int d = 0; d < 250; d++) begin
      case ($urandom_range(0, 9))
        6:       sg = 7'h7F;
        7:       sg = 7'($urandom);
        default: sg = seg_table[$urandom_range(0, 15)];
      endcase
      case ($urandom_range(0, 9))
        0:       dg = 2'b00;
        1:       dg = 2'b11;
        2, 3, 4, 5: dg = 2'b10;
        default: dg = 2'b01;
      endcase
      seg_in = sg;
      dig_in = dg;
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
        err_clr = ($urandom_range(0, 15) == 0);
        tick(v);
      end
    end
    err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
